game_flow_manager: RTL and testbench

Parametrised game-flow controller for the Bumpy game: sequences the attract/idle, play, level-won, died, game-over and game-won phases. Tracks the current level and remaining lives, and times each interstitial screen from a one-second tick. Gates the gameplay FSMs through reset_fsm_N. Sits between the top-level game logic (death/level-complete events) and the screen muxer.

---
 rtl/game_flow_manager_pkg.sv | 20 ++
 rtl/game_flow_manager_if.sv | 34 +++
 rtl/game_flow_manager_screen_timer.sv | 42 ++++
 rtl/game_flow_manager.sv | 153 +++++++++++++++
 tb/tb_game_flow_manager.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/game_flow_manager_pkg.sv
// Shared phase encoding for the game-flow controller and the screen muxer.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package game_flow_pkg;

    typedef enum logic [2:0] {
        SCR_IDLE    = 3'd0,
        SCR_PLAY    = 3'd1,
        SCR_WIN     = 3'd2,
        SCR_DIED    = 3'd3,
        SCR_OVER    = 3'd4,
        SCR_VICTORY = 3'd5
    } screen_t;

    // Phases that show a timed interstitial screen.
    function automatic logic is_screen(screen_t s);
        return (s == SCR_WIN) || (s == SCR_DIED) || (s == SCR_OVER) || (s == SCR_VICTORY);
    endfunction

endpackage

// File: rtl/game_flow_manager_if.sv
// Event inputs and status outputs between game logic, flow manager and screen muxer.
// Latency: n/a (wiring only).
// Backpressure: none; events are levels, status is continuously valid.
interface game_flow_manager_if
    import game_flow_pkg::*;
#(
    parameter int LVL_W   = 3,
    parameter int LIVES_W = 2,
    parameter int TIMER_W = 4
);
    logic               one_sec;
    logic               start;
    logic               skip;
    logic               bumpy_died;
    logic               level_comp;
    screen_t            screen_id;
    logic [LVL_W-1:0]   lvl;
    logic [LIVES_W-1:0] lives;
    logic               reset_fsm_N;
    logic               level_start;
    logic [TIMER_W-1:0] secs_left;

    // Game logic side: raises events, observes the phase.
    modport master (
        output one_sec, start, skip, bumpy_died, level_comp,
        input  screen_id, lvl, lives, reset_fsm_N, level_start, secs_left
    );

    // Flow manager side.
    modport slave (
        input  one_sec, start, skip, bumpy_died, level_comp,
        output screen_id, lvl, lives, reset_fsm_N, level_start, secs_left
    );
endinterface

// File: rtl/game_flow_manager_screen_timer.sv
// Down-counter timing interstitial screens in one_sec ticks.
// Latency: count updates one cycle after load/clear/tick; done is combinational.
// Backpressure: none; load beats clear beats tick, and a tick on the load cycle is lost.
module screen_timer #(
    parameter int TIMER_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               tick,
    input  logic               clear,
    output logic [TIMER_W-1:0] count,
    output logic               done
);
    logic [TIMER_W-1:0] count_q, count_d;

    // Next count: reload, clear, or decrement on a tick, saturating at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (clear) begin
            count_d = '0;
        end else if (tick && (count_q != '0)) begin
            count_d = count_q - TIMER_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign done  = (count_q == '0) && !load;

endmodule

// File: rtl/game_flow_manager.sv
// Game-flow controller: sequences idle/play/won/died/over/victory, tracks level and lives.
// Latency: outputs change one cycle after the qualifying event edge or timer expiry.
// Backpressure: none; event edges that arrive outside the state that uses them are dropped.
module game_flow_manager
    import game_flow_pkg::*;
#(
    parameter int NUM_LEVELS  = 4,
    parameter int LVL_W       = 3,
    parameter int START_LIVES = 3,
    parameter int LIVES_W     = 2,
    parameter int SCREEN_SEC  = 3,
    parameter int END_SEC     = 5,
    parameter int TIMER_W     = 4
) (
    input logic                clk,
    input logic                reset,
    game_flow_manager_if.slave bus
);
    localparam logic [LVL_W-1:0]   LVL_LAST   = LVL_W'(NUM_LEVELS - 1);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(START_LIVES);
    localparam logic [TIMER_W-1:0] T_SCREEN   = TIMER_W'(SCREEN_SEC);
    localparam logic [TIMER_W-1:0] T_END      = TIMER_W'(END_SEC);

    screen_t            state_q, state_d;
    logic [LVL_W-1:0]   lvl_q, lvl_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [3:0]         ev_prev_q, ev_prev_d;
    logic               level_start_q, level_start_d;
    logic               reset_fsm_n_q, reset_fsm_n_d;

    logic [3:0]         ev_now, ev_rise;
    logic               start_rise, skip_rise, died_rise, comp_rise;
    logic               tmr_load, tmr_clear, tmr_done;
    logic [TIMER_W-1:0] tmr_val, tmr_count;

    // Rising-edge detection against last cycle's levels.
    always_comb begin
        ev_now     = {bus.start, bus.skip, bus.bumpy_died, bus.level_comp};
        ev_prev_d  = ev_now;
        ev_rise    = ev_now & ~ev_prev_q;
        start_rise = ev_rise[3];
        skip_rise  = ev_rise[2];
        died_rise  = ev_rise[1];
        comp_rise  = ev_rise[0];
    end

    screen_timer #(.TIMER_W(TIMER_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tick     (bus.one_sec),
        .clear    (tmr_clear),
        .count    (tmr_count),
        .done     (tmr_done)
    );

    // Phase transitions, level/lives updates and timer control.
    always_comb begin
        state_d   = state_q;
        lvl_d     = lvl_q;
        lives_d   = lives_q;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        tmr_clear = 1'b0;
        case (state_q)
            SCR_IDLE: begin
                if (start_rise) begin
                    state_d = SCR_PLAY;
                    lvl_d   = '0;
                    lives_d = LIVES_INIT;
                end
            end
            SCR_PLAY: begin
                // Level completion takes precedence over a simultaneous death.
                if (comp_rise) begin
                    tmr_load = 1'b1;
                    if (lvl_q == LVL_LAST) begin
                        state_d = SCR_VICTORY;
                        tmr_val = T_END;
                    end else begin
                        state_d = SCR_WIN;
                        lvl_d   = lvl_q + LVL_W'(1);
                        tmr_val = T_SCREEN;
                    end
                end else if (died_rise) begin
                    tmr_load = 1'b1;
                    lives_d  = lives_q - LIVES_W'(1);
                    if (lives_q == LIVES_W'(1)) begin
                        state_d = SCR_OVER;
                        tmr_val = T_END;
                    end else begin
                        state_d = SCR_DIED;
                        tmr_val = T_SCREEN;
                    end
                end
            end
            SCR_WIN, SCR_DIED: begin
                if (skip_rise) begin
                    state_d   = SCR_PLAY;
                    tmr_clear = 1'b1;
                end else if (tmr_done) begin
                    state_d = SCR_PLAY;
                end
            end
            SCR_OVER, SCR_VICTORY: begin
                if (skip_rise) begin
                    state_d   = SCR_IDLE;
                    tmr_clear = 1'b1;
                end else if (tmr_done) begin
                    state_d = SCR_IDLE;
                end
            end
            default: begin
                state_d   = SCR_IDLE;
                tmr_clear = 1'b1;
            end
        endcase
    end

    // Registered decodes so gameplay sees clean, glitch-free controls.
    always_comb begin
        level_start_d = (state_d == SCR_PLAY) && (state_q != SCR_PLAY);
        reset_fsm_n_d = (state_d == SCR_PLAY);
    end

    // State, counters, edge history and decoded outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= SCR_IDLE;
            lvl_q         <= '0;
            lives_q       <= LIVES_INIT;
            ev_prev_q     <= '0;
            level_start_q <= 1'b0;
            reset_fsm_n_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            lvl_q         <= lvl_d;
            lives_q       <= lives_d;
            ev_prev_q     <= ev_prev_d;
            level_start_q <= level_start_d;
            reset_fsm_n_q <= reset_fsm_n_d;
        end
    end

    assign bus.screen_id   = state_q;
    assign bus.lvl         = lvl_q;
    assign bus.lives       = lives_q;
    assign bus.reset_fsm_N = reset_fsm_n_q;
    assign bus.level_start = level_start_q;
    assign bus.secs_left   = is_screen(state_q) ? tmr_count : '0;

endmodule

// File: tb/tb_game_flow_manager.sv
// Scoreboard bench: driver updates a phase-level reference model and queues the expected
// outputs for each cycle; a monitor on the falling edge pops and compares.
module tb_game_flow_manager;
    import game_flow_pkg::*;

    localparam int NUM_LEVELS  = 4;
    localparam int LVL_W       = 3;
    localparam int START_LIVES = 3;
    localparam int LIVES_W     = 2;
    localparam int SCREEN_SEC  = 3;
    localparam int END_SEC     = 5;
    localparam int TIMER_W     = 4;

    localparam int P_IDLE = 0, P_PLAY = 1, P_WIN = 2, P_DIED = 3, P_OVER = 4, P_VICT = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    game_flow_manager_if #(.LVL_W(LVL_W), .LIVES_W(LIVES_W), .TIMER_W(TIMER_W)) bus ();

    game_flow_manager #(
        .NUM_LEVELS (NUM_LEVELS), .LVL_W(LVL_W), .START_LIVES(START_LIVES),
        .LIVES_W(LIVES_W), .SCREEN_SEC(SCREEN_SEC), .END_SEC(END_SEC), .TIMER_W(TIMER_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int scr;
        int lvl;
        int lives;
        int rfsm;
        int lstart;
        int secs;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: game phase, level, lives, seconds left on the current screen.
    int m_phase, m_lvl, m_lives, m_rem, m_lstart, m_rfsm;
    bit m_prev[4];
    bit ev[4];   // 0 start, 1 skip, 2 bumpy_died, 3 level_comp

    function automatic exp_t model_out();
        exp_t e;
        e.scr    = m_phase;
        e.lvl    = m_lvl;
        e.lives  = m_lives;
        e.rfsm   = m_rfsm;
        e.lstart = m_lstart;
        e.secs   = (m_phase >= P_WIN) ? m_rem : 0;
        return e;
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE; m_lvl = 0; m_lives = START_LIVES; m_rem = 0;
        m_lstart = 0; m_rfsm = 0;
        for (int k = 0; k < 4; k++) m_prev[k] = 1'b0;
    endtask

    task automatic model_step(input bit os);
        bit rise[4];
        int old;
        for (int k = 0; k < 4; k++) begin
            rise[k]   = ev[k] && !m_prev[k];
            m_prev[k] = ev[k];
        end
        old = m_phase;
        if (m_phase == P_IDLE) begin
            if (rise[0]) begin
                m_phase = P_PLAY; m_lvl = 0; m_lives = START_LIVES;
            end
        end else if (m_phase == P_PLAY) begin
            if (rise[3]) begin
                if (m_lvl == NUM_LEVELS - 1) begin
                    m_phase = P_VICT; m_rem = END_SEC;
                end else begin
                    m_lvl = m_lvl + 1; m_phase = P_WIN; m_rem = SCREEN_SEC;
                end
            end else if (rise[2]) begin
                m_lives = m_lives - 1;
                if (m_lives == 0) begin
                    m_phase = P_OVER; m_rem = END_SEC;
                end else begin
                    m_phase = P_DIED; m_rem = SCREEN_SEC;
                end
            end
        end else begin
            // Any screen: leave on skip or once the count has run out, else count ticks.
            if (rise[1] || m_rem == 0) begin
                m_phase = (m_phase == P_WIN || m_phase == P_DIED) ? P_PLAY : P_IDLE;
                m_rem   = 0;
            end else if (os) begin
                m_rem = m_rem - 1;
            end
        end
        m_lstart = (m_phase == P_PLAY && old != P_PLAY) ? 1 : 0;
        m_rfsm   = (m_phase == P_PLAY) ? 1 : 0;
    endtask

    // One cycle of stimulus; reset acts immediately, so it also rewrites the pending sample.
    task automatic cyc(input bit os, input bit rs);
        bus.one_sec    = os;
        bus.start      = ev[0];
        bus.skip       = ev[1];
        bus.bumpy_died = ev[2];
        bus.level_comp = ev[3];
        reset          = rs;
        if (rs) begin
            model_reset();
            if (exp_q.size() > 0) exp_q[exp_q.size() - 1] = model_out();
        end else begin
            model_step(os);
        end
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int k);
        ev[k] = 1'b1; cyc(1'b0, 1'b0);
        ev[k] = 1'b0; cyc(1'b0, 1'b0);
    endtask

    task automatic tick_out(input int n);
        repeat (n) begin
            cyc(1'b1, 1'b0);
            cyc(1'b0, 1'b0);
        end
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
    endtask

    // Monitor: compare every cycle's outputs against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if (int'(bus.screen_id) != e.scr || int'(bus.lvl) != e.lvl ||
                    int'(bus.lives) != e.lives || int'(bus.reset_fsm_N) != e.rfsm ||
                    int'(bus.level_start) != e.lstart || int'(bus.secs_left) != e.secs) begin
                    fails++;
                    $display("FAIL outputs @%0t: got scr=%0d lvl=%0d lives=%0d rfsm=%0d lstart=%0d secs=%0d, want scr=%0d lvl=%0d lives=%0d rfsm=%0d lstart=%0d secs=%0d",
                             $time, bus.screen_id, bus.lvl, bus.lives, bus.reset_fsm_N,
                             bus.level_start, bus.secs_left, e.scr, e.lvl, e.lives,
                             e.rfsm, e.lstart, e.secs);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 4; k++) ev[k] = 1'b0;
        model_reset();
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);

        // Start, then complete level 0 and wait out the won screen.
        pulse(0);
        pulse(3);
        tick_out(SCREEN_SEC);

        // Three deaths: two died screens, then game over timing out to idle.
        pulse(2); tick_out(SCREEN_SEC);
        pulse(2); tick_out(SCREEN_SEC);
        pulse(2); tick_out(END_SEC);

        // Play through every level, skipping screens; last completion wins.
        pulse(0);
        repeat (NUM_LEVELS - 1) begin
            pulse(3);
            pulse(1);
        end
        pulse(3);
        pulse(1);

        // Down to one life, then simultaneous completion and death with death held high.
        pulse(0);
        pulse(2); pulse(1);
        pulse(2); pulse(1);
        ev[2] = 1'b1; ev[3] = 1'b1; cyc(1'b0, 1'b0);
        ev[3] = 1'b0; cyc(1'b0, 1'b0);
        pulse(1);
        repeat (4) cyc(1'b0, 1'b0);
        ev[2] = 1'b0; cyc(1'b0, 1'b0);

        // Reset in the middle of a died screen, with a tick during reset.
        pulse(2);
        pulse(1);
        pulse(0);
        pulse(2);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);

        // Randomised play.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0)  ev[0] = ~ev[0];
            if ($urandom_range(0, 9) == 0)  ev[1] = ~ev[1];
            if ($urandom_range(0, 11) == 0) ev[2] = ~ev[2];
            if ($urandom_range(0, 5) == 0)  ev[3] = ~ev[3];
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 399) == 0);
        end

        for (int k = 0; k < 4; k++) ev[k] = 1'b0;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
